// File: rtl/tl_ul_arbiter.sv
// Two-master TileLink-UL arbiter: round-robin A-channel grant onto one slave
// port, source-MSB based D-channel return routing, per-master outstanding
// request accounting with an unexpected-response error pulse.

`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 5
`endif
`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif

module tl_ul_arbiter #(
  parameter int MAX_OUT = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // master 0 A
  input  logic                          m0_a_valid,
  output logic                          m0_a_ready,
  input  logic [2:0]                    m0_a_opcode,
  input  logic [`TL_SOURCE_BITS-2:0]    m0_a_source,
  input  logic [`TL_ADDR_BITS-1:0]      m0_a_address,
  input  logic [`TL_DATA_BYTES-1:0]     m0_a_mask,
  input  logic [`TL_DATA_BYTES*8-1:0]   m0_a_data,
  // master 0 D
  output logic                          m0_d_valid,
  input  logic                          m0_d_ready,
  output logic [3:0]                    m0_d_opcode,
  output logic [`TL_SOURCE_BITS-2:0]    m0_d_source,
  output logic [`TL_DATA_BYTES*8-1:0]   m0_d_data,
  // master 1 A
  input  logic                          m1_a_valid,
  output logic                          m1_a_ready,
  input  logic [2:0]                    m1_a_opcode,
  input  logic [`TL_SOURCE_BITS-2:0]    m1_a_source,
  input  logic [`TL_ADDR_BITS-1:0]      m1_a_address,
  input  logic [`TL_DATA_BYTES-1:0]     m1_a_mask,
  input  logic [`TL_DATA_BYTES*8-1:0]   m1_a_data,
  // master 1 D
  output logic                          m1_d_valid,
  input  logic                          m1_d_ready,
  output logic [3:0]                    m1_d_opcode,
  output logic [`TL_SOURCE_BITS-2:0]    m1_d_source,
  output logic [`TL_DATA_BYTES*8-1:0]   m1_d_data,
  // shared slave A
  output logic                          s_a_valid,
  input  logic                          s_a_ready,
  output logic [2:0]                    s_a_opcode,
  output logic [`TL_SOURCE_BITS-1:0]    s_a_source,
  output logic [`TL_ADDR_BITS-1:0]      s_a_address,
  output logic [`TL_DATA_BYTES-1:0]     s_a_mask,
  output logic [`TL_DATA_BYTES*8-1:0]   s_a_data,
  // shared slave D
  input  logic                          s_d_valid,
  output logic                          s_d_ready,
  input  logic [3:0]                    s_d_opcode,
  input  logic [`TL_SOURCE_BITS-1:0]    s_d_source,
  input  logic [`TL_DATA_BYTES*8-1:0]   s_d_data,
  // status
  output logic [3:0]                    out0_count,
  output logic [3:0]                    out1_count,
  output logic                          err_unexpected_d
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;

  state_e state_q, state_d;
  logic   rr_ptr;
  logic   elig0, elig1, pick0, pick1;
  logic   gnt0, gnt1;
  logic   a_fire, d_fire, d_idx;
  logic   inc0, inc1, dec0, dec1, err_d;

  // Eligibility and the combinational IDLE pick; rr_ptr breaks ties.
  assign elig0 = m0_a_valid && (out0_count < MAX_CNT);
  assign elig1 = m1_a_valid && (out1_count < MAX_CNT);
  assign pick0 = elig0 && (!elig1 || !rr_ptr);
  assign pick1 = elig1 && (!elig0 ||  rr_ptr);

  // State register.
  // NOTE: reset is synchronous, so it is sampled inside the clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: an IDLE pick that stalls becomes a held grant until it fires.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick0 && !s_a_ready)      state_d = GRANT0;
        else if (pick1 && !s_a_ready) state_d = GRANT1;
      end
      GRANT0: if (!m0_a_valid || s_a_ready) state_d = IDLE;
      GRANT1: if (!m1_a_valid || s_a_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: A-channel mux driven by the effective grant, gated off in reset.
  always_comb begin
    gnt0        = rst_n && ((state_q == GRANT0) || ((state_q == IDLE) && pick0));
    gnt1        = rst_n && ((state_q == GRANT1) || ((state_q == IDLE) && pick1));
    s_a_valid   = 1'b0;
    s_a_opcode  = '0;
    s_a_source  = '0;
    s_a_address = '0;
    s_a_mask    = '0;
    s_a_data    = '0;
    m0_a_ready  = 1'b0;
    m1_a_ready  = 1'b0;
    if (gnt0) begin
      s_a_valid   = m0_a_valid;
      s_a_opcode  = m0_a_opcode;
      s_a_source  = {1'b0, m0_a_source};
      s_a_address = m0_a_address;
      s_a_mask    = m0_a_mask;
      s_a_data    = m0_a_data;
      m0_a_ready  = s_a_ready;
    end else if (gnt1) begin
      s_a_valid   = m1_a_valid;
      s_a_opcode  = m1_a_opcode;
      s_a_source  = {1'b1, m1_a_source};
      s_a_address = m1_a_address;
      s_a_mask    = m1_a_mask;
      s_a_data    = m1_a_data;
      m1_a_ready  = s_a_ready;
    end
  end

  // D routing: source MSB selects the master; payload passes through.
  always_comb begin
    d_idx       = s_d_source[`TL_SOURCE_BITS-1];
    m0_d_valid  = s_d_valid && !d_idx;
    m1_d_valid  = s_d_valid &&  d_idx;
    s_d_ready   = d_idx ? m1_d_ready : m0_d_ready;
    m0_d_opcode = s_d_opcode;
    m1_d_opcode = s_d_opcode;
    m0_d_source = s_d_source[`TL_SOURCE_BITS-2:0];
    m1_d_source = s_d_source[`TL_SOURCE_BITS-2:0];
    m0_d_data   = s_d_data;
    m1_d_data   = s_d_data;
  end

  // Count update terms; a D to a master with nothing outstanding is an error.
  always_comb begin
    a_fire = s_a_valid && s_a_ready;
    d_fire = s_d_valid && s_d_ready;
    inc0   = a_fire && gnt0;
    inc1   = a_fire && gnt1;
    dec0   = d_fire && !d_idx && (out0_count != 4'd0);
    dec1   = d_fire &&  d_idx && (out1_count != 4'd0);
    err_d  = d_fire && (d_idx ? (out1_count == 4'd0) : (out0_count == 4'd0));
  end

  // Round-robin pointer, outstanding counters and error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      rr_ptr           <= 1'b0;
      out0_count       <= 4'd0;
      out1_count       <= 4'd0;
      err_unexpected_d <= 1'b0;
    end else begin
      if (inc0) rr_ptr <= 1'b1;
      if (inc1) rr_ptr <= 1'b0;
      if (inc0 && !dec0)      out0_count <= out0_count + 4'd1;
      else if (dec0 && !inc0) out0_count <= out0_count - 4'd1;
      if (inc1 && !dec1)      out1_count <= out1_count + 4'd1;
      else if (dec1 && !inc1) out1_count <= out1_count - 4'd1;
      err_unexpected_d <= err_d;
    end
  end

endmodule

// File: doc/tl_ul_arbiter.md
TL_UL_ARBITER -- requirements
Module: tl_ul_arbiter

Interface
REQ-001 Parameter MAX_OUT, default 4: maximum outstanding requests per master (1..15).
REQ-002 Macros from tl_pkg.vh: `TL_SOURCE_BITS, `TL_ADDR_BITS, `TL_DATA_BYTES; SW = `TL_SOURCE_BITS-1 is the master-side source width; DW = `TL_DATA_BYTES*8.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 mN_a_valid/mN_a_ready  in/out  1/1  master N (N=0,1) A handshake.
REQ-006 mN_a_opcode/mN_a_source/mN_a_address/mN_a_mask/mN_a_data  in  3/SW/`TL_ADDR_BITS/`TL_DATA_BYTES/DW  master N A payload.
REQ-007 mN_d_valid/mN_d_ready  out/in  1/1  master N D handshake.
REQ-008 mN_d_opcode/mN_d_source/mN_d_data  out  4/SW/DW  master N D payload.
REQ-009 s_a_valid/s_a_ready  out/in  1/1; s_a_opcode/s_a_source/s_a_address/s_a_mask/s_a_data  out  3/`TL_SOURCE_BITS/`TL_ADDR_BITS/`TL_DATA_BYTES/DW  shared slave A port.
REQ-010 s_d_valid/s_d_ready  in/out  1/1; s_d_opcode/s_d_source/s_d_data  in  4/`TL_SOURCE_BITS/DW  shared slave D port.
REQ-011 outN_count  out  4  outstanding count of master N; err_unexpected_d  out  1  one-cycle error pulse.

Function
REQ-012 State machine states: IDLE (no grant), GRANT0 (master 0 owns A), GRANT1 (master 1 owns A).
REQ-013 Eligibility: master N is eligible when mN_a_valid=1 and outN_count<MAX_OUT.
REQ-014 IDLE: if exactly one master is eligible, grant it; if both are eligible, grant the master named by rr_ptr.
REQ-015 Grant decision in IDLE is combinational, so s_a_valid may assert in the same cycle that mN_a_valid rises (zero added latency).
REQ-016 GRANTn: s_a_* = mn_a_* with s_a_source = {n, mn_a_source}; mn_a_ready = s_a_ready; the other master's a_ready = 0.
REQ-017 A grant is held while s_a_valid=1 and s_a_ready=0, so the payload stays stable until it fires.
REQ-018 On an A fire from master n: rr_ptr <= ~n, outn_count increments, and the FSM returns to IDLE.
REQ-019 The ungranted or ineligible master sees a_ready=0; s_a_valid=0 in IDLE when no master is eligible.
REQ-020 D routing: index k = s_d_source[`TL_SOURCE_BITS-1]; mk_d_valid = s_d_valid and mk_d_source = s_d_source[SW-1:0].
REQ-021 D routing: s_d_ready = mk_d_ready; the other master's d_valid = 0; opcode and data pass through unchanged.
REQ-022 D routing is purely combinational and independent of A-channel state.
REQ-023 On a D fire to master k with outk_count>0, outk_count decrements.
REQ-024 On a D fire to master k with outk_count=0, the response is still forwarded, the count stays 0, and err_unexpected_d pulses high for 1 cycle.
REQ-025 Same-cycle A fire and D fire for the same master leave its count unchanged; for different masters both updates apply.
REQ-026 A master at MAX_OUT is blocked. It becomes eligible in the cycle after its count drops below MAX_OUT.
REQ-027 A master at MAX_OUT never loses an already-held grant: REQ-017 takes precedence over REQ-013 once the grant is issued.

Reset
REQ-028 While rst_n=0 at a clock edge, the block sets: FSM=IDLE, rr_ptr=0, out0_count=out1_count=0, err_unexpected_d=0.
REQ-029 During reset, mN_a_ready=0 and s_a_valid=0 regardless of inputs; D routing stays combinational.
REQ-030 Reset mid-transaction discards the grant and all counts; post-reset responses to pre-reset requests raise err_unexpected_d.

Verification
REQ-031 Single master: m0 sends GET addr 0x10 source 3 -> s_a_source=0x03 in the same cycle, out0_count=1; slave ACCESSACKDATA with source 0x03 -> m0_d_valid=1, m0_d_source=3, out0_count=0.
REQ-032 Contention: both masters valid from reset with s_a_ready=1 -> fires alternate m0, m1, m0, m1, and no master fires twice in a row while the other is eligible.
REQ-033 Backpressure: m1 granted, s_a_ready=0 for 3 cycles while m0 asserts valid -> s_a_* holds m1's payload unchanged, m0_a_ready=0 throughout, and m1 fires on cycle 4.
REQ-034 Limit: MAX_OUT=4, m0 issues 4 PUTFULLs with no D responses -> 5th request blocked (m0_a_ready=0, out0_count=4); one ACCESSACK -> 5th fires on the following cycle.
REQ-035 Simultaneous events and errors:
- m0 A fire and m0 D fire in the same cycle -> out0_count unchanged.
- D with source MSB=1 while out1_count=0 -> forwarded to m1, err_unexpected_d=1 for exactly 1 cycle.
REQ-036 Reset mid-op: assert rst_n=0 while GRANT1 is held under backpressure -> next cycle s_a_valid=0, both counts=0, rr_ptr=0.
